// File: rtl/keccak_round_ctrl_pkg.sv
// Shared definitions for the Keccak-f[1600] round sequencer.
//   KECCAK_NUM_ROUNDS : number of permutation rounds (one-hot index width)
//   KECCAK_CNT_W      : width of the binary round number
//   KECCAK_ONEHOT_W   : one-hot round index width, shared with the
//                       round-constant generator
//   state_t           : controller FSM states
package keccak_pkg;

  localparam int unsigned KECCAK_NUM_ROUNDS = 24;
  localparam int unsigned KECCAK_CNT_W      = $clog2(KECCAK_NUM_ROUNDS);
  localparam int unsigned KECCAK_ONEHOT_W   = KECCAK_NUM_ROUNDS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Block handshake bundle between padder, round controller and squeeze stage.
//   in_valid/in_ready/in_last : absorbed block offer from the padder
//   load                      : block XOR strobe (accept this cycle)
//   out_valid/out_ready/out_last : completed-permutation handshake
// Modports: master = padder/squeeze side, slave = round controller.
interface keccak_round_ctrl_if;

  logic in_valid;
  logic in_last;
  logic in_ready;
  logic load;
  logic out_valid;
  logic out_last;
  logic out_ready;

  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, load, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, load, out_valid, out_last
  );

endinterface

// File: rtl/keccak_round_ctrl_onehot_shifter.sv
// One-hot round index register with a binary round counter kept in lockstep.
//   clk, reset : clock, synchronous active-high reset
//   start      : load round 0 (onehot = bit 0, num = 0)
//   advance    : step to the next round; stepping past the final round
//                clears both registers (no wrap)
//   onehot     : one-hot round index, zero when no round is active
//   num        : binary round number, zero when idle
//   last       : final round is currently active
module round_onehot_shifter #(
  parameter int unsigned NUM_ROUNDS = 24,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  advance,
  output logic [NUM_ROUNDS-1:0] onehot,
  output logic [CNT_W-1:0]      num,
  output logic                  last
);

  assign last = onehot[NUM_ROUNDS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      onehot <= '0;
      num    <= '0;
    end else if (start) begin
      onehot <= NUM_ROUNDS'(1);
      num    <= '0;
    end else if (advance) begin
      if (last) begin
        onehot <= '0;
        num    <= '0;
      end else begin
        onehot <= {onehot[NUM_ROUNDS-2:0], 1'b0};
        num    <= num + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the low-throughput Keccak-f[1600] core.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : block accept / completion handshake (see keccak_round_ctrl_if)
//   round_onehot : one-hot round index for the round-constant generator
//   round_num    : binary round number, 0 when idle
//   round_en     : datapath applies one round this cycle
//   busy         : permutation in progress or result pending
module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = KECCAK_NUM_ROUNDS,
  parameter int unsigned CNT_W      = KECCAK_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  keccak_round_ctrl_if.slave    bus,
  output logic [NUM_ROUNDS-1:0] round_onehot,
  output logic [CNT_W-1:0]      round_num,
  output logic                  round_en,
  output logic                  busy
);

  state_t state;
  state_t state_next;
  logic   accept;
  logic   last_round;
  logic   last_reg;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.load      = accept;
  assign bus.out_valid = (state == DONE);
  assign bus.out_last  = last_reg;
  assign round_en      = (state == ROUND);
  assign busy          = (state == ROUND) || (state == DONE);

  round_onehot_shifter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .advance (state == ROUND),
    .onehot  (round_onehot),
    .num     (round_num),
    .last    (last_round)
  );

  // DONE with out_ready and in_valid together consumes the result and
  // starts the next block in the same cycle, so no idle bubble appears.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ROUND;
      ROUND:   if (last_round) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = accept ? ROUND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) last_reg <= bus.in_last;
    end
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
module tb_keccak_round_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] round_onehot;
  logic [4:0]  round_num;
  logic        round_en;
  logic        busy;

  int checks = 0;
  int errors = 0;

  keccak_round_ctrl_if bus ();

  keccak_round_ctrl #(
    .NUM_ROUNDS (24),
    .CNT_W      (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .round_onehot (round_onehot),
    .round_num    (round_num),
    .round_en     (round_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, round_onehot, round_num, round_en, bus.out_valid, bus.out_last, busy} !==
        {1'b1, 24'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b oh=%h num=%0d en=%b ov=%b ol=%b busy=%b, required rdy=1 rest 0",
               bus.in_ready, round_onehot, round_num, round_en, bus.out_valid, bus.out_last, busy);
    end
  endtask

  task automatic test_single_block();
    logic [23:0] exp_oh;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    #1;
    checks++;
    if (bus.load !== 1'b1) begin
      errors++;
      $display("FAIL single_load: load=%b required 1", bus.load);
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      exp_oh = 24'h1 << (k - 1);
      checks++;
      if (round_onehot !== exp_oh || round_num !== 5'(k - 1) || round_en !== 1'b1 ||
          busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_round%0d: oh=%h num=%0d en=%b busy=%b ov=%b rdy=%b, required oh=%h num=%0d en=1 busy=1 ov=0 rdy=0",
                 k, round_onehot, round_num, round_en, busy, bus.out_valid, bus.in_ready, exp_oh, k - 1);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || round_en !== 1'b0 || round_onehot !== 24'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: ov=%b en=%b oh=%h busy=%b, required ov=1 en=0 oh=0 busy=1",
               bus.out_valid, round_en, round_onehot, busy);
    end
  endtask

  // Starts in DONE from test_single_block.
  task automatic test_hold_done();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || round_onehot !== 24'h0) begin
        errors++;
        $display("FAIL hold_done%0d: ov=%b rdy=%b oh=%h, required ov=1 rdy=0 oh=0",
                 k, bus.out_valid, bus.in_ready, round_onehot);
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.load !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: rdy=%b load=%b, required rdy=1 load=0", bus.in_ready, bus.load);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_idle: ov=%b busy=%b rdy=%b, required ov=0 busy=0 rdy=1",
               bus.out_valid, busy, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b1;  // must be ignored while not accepting
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 25 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: latency=%0d out_last=%b, required latency=25 out_last=0", lat, bus.out_last);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_last = 1'b1;
    #1;
    checks++;
    if (bus.load !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load: load=%b rdy=%b, required load=1 rdy=1", bus.load, bus.in_ready);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    checks++;
    if (round_onehot !== 24'h1 || round_en !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: oh=%h en=%b ov=%b, required oh=000001 en=1 ov=0",
               round_onehot, round_en, bus.out_valid);
    end
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 25 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: latency=%0d out_last=%b, required latency=25 out_last=1", lat, bus.out_last);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    checks++;
    if (round_num !== 5'd11 || round_onehot !== 24'h000800) begin
      errors++;
      $display("FAIL midrst_pre: num=%0d oh=%h, required num=11 oh=000800", round_num, round_onehot);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (round_onehot !== 24'h0 || round_en !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: oh=%h en=%b ov=%b rdy=%b ol=%b, required oh=0 en=0 ov=0 rdy=1 ol=0",
               round_onehot, round_en, bus.out_valid, bus.in_ready, bus.out_last);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 25) begin
      errors++;
      $display("FAIL midrst_fresh: latency=%0d, required 25", lat);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int accepts = 0;
    int completions = 0;
    int bad = 0;
    for (int c = 0; c < 1040; c++) begin
      @(negedge clk);
      if (c < 1000) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_last = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
      end
      #1;
      if (bus.load === 1'b1) accepts++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) completions++;
      if ((round_onehot & (round_onehot - 24'h1)) !== 24'h0 ||
          round_onehot[round_num] !== round_en) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_invariant cycle %0d: oh=%h num=%0d en=%b, required onehot/zero with oh[num]==en",
                   c, round_onehot, round_num, round_en);
      end
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_invariant_total: violations=%0d required 0", bad);
    end
    checks++;
    if (accepts != completions || accepts == 0) begin
      errors++;
      $display("FAIL random_count: accepts=%0d completions=%0d, required equal and nonzero", accepts, completions);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_hold_done();
    test_back_to_back();
    test_reset_mid_round();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
